short_preamble_detector: RTL and testbench



---
 rtl/short_preamble_detector.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_short_preamble_detector.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/short_preamble_detector.sv
// Delay-and-correlate short preamble detector. Passes samples through a
// 4-stage pipeline and flags the sample where the autocorrelation plateau ends.
// Define SHORT_PREAMBLE_DET_DEBUG_EN to add the o_metric / o_power outputs.
module short_preamble_detector #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PERIOD      = 16,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned THRESH      = 12,
  parameter int unsigned POWER_MIN   = 2**20,
  parameter int unsigned MIN_PLATEAU = 64,
  parameter int unsigned MAX_PLATEAU = 256,
  parameter int unsigned HOLDOFF     = 512
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [WIDTH-1:0]              i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [WIDTH-1:0]              o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
`ifdef SHORT_PREAMBLE_DET_DEBUG_EN
  output logic [WIDTH+$clog2(WINDOW):0] o_metric,
  output logic [WIDTH+$clog2(WINDOW):0] o_power,
`endif
  input  logic                          o_tready
);

  localparam int unsigned HW  = WIDTH / 2;
  localparam int unsigned PW  = WIDTH + 1;
  localparam int unsigned SW  = WIDTH + 1 + $clog2(WINDOW);
  localparam int unsigned CW  = $clog2(MAX_PLATEAU + 1);
  localparam int unsigned HCW = $clog2(HOLDOFF + 1);

  localparam logic [1:0] S_SEARCH   = 2'd0;
  localparam logic [1:0] S_PLATEAU  = 2'd1;
  localparam logic [1:0] S_WAIT_END = 2'd2;
  localparam logic [1:0] S_HOLDOFF  = 2'd3;

  logic adv, acc;
  logic [WIDTH-1:0] xdl_q [PERIOD];
  logic [WIDTH-1:0] xdl_d [PERIOD];
  logic [WIDTH-1:0] y;
  logic signed [PW-1:0] ix, qx, iy, qy, c_re, c_im, c_p;

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d, s3_data_q, s3_data_d;
  logic signed [PW-1:0] s1_re_q, s1_re_d, s1_im_q, s1_im_d, s1_p_q, s1_p_d;
  logic s3_tlast_q, s3_tlast_d;
  logic o_tvalid_q, o_tvalid_d, o_tlast_q, o_tlast_d;
  logic [WIDTH-1:0] o_tdata_q, o_tdata_d;

  logic signed [PW-1:0] pdl_re_q [WINDOW];
  logic signed [PW-1:0] pdl_re_d [WINDOW];
  logic signed [PW-1:0] pdl_im_q [WINDOW];
  logic signed [PW-1:0] pdl_im_d [WINDOW];
  logic signed [PW-1:0] pdl_p_q  [WINDOW];
  logic signed [PW-1:0] pdl_p_d  [WINDOW];
  logic signed [SW-1:0] sum_re_q, sum_re_d, sum_im_q, sum_im_d;
  logic [SW-1:0] sum_r_q, sum_r_d;

  logic [SW-1:0] re_abs, im_abs, mx, mn, mag, thr;
  logic [SW+3:0] r_thr;
  logic above, evt;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HCW-1:0] hcnt_q, hcnt_d, hcnt_inc;

  // The whole pipeline moves together; history only moves on accepted samples.
  assign adv      = ~o_tvalid_q | o_tready;
  assign acc      = adv & i_tvalid;
  assign i_tready = adv;
  assign o_tvalid = o_tvalid_q;
  assign o_tdata  = o_tdata_q;
  assign o_tlast  = o_tlast_q;

  // Stage 1: lagged sample and the correlation / power products.
  always_comb begin
    y    = xdl_q[PERIOD-1];
    ix   = PW'($signed(i_tdata[WIDTH-1:HW]));
    qx   = PW'($signed(i_tdata[HW-1:0]));
    iy   = PW'($signed(y[WIDTH-1:HW]));
    qy   = PW'($signed(y[HW-1:0]));
    c_re = ix * iy + qx * qy;
    c_im = qx * iy - ix * qy;
    c_p  = iy * iy + qy * qy;
    xdl_d = xdl_q;
    if (acc) begin
      xdl_d[0] = i_tdata;
      for (int i = 1; i < PERIOD; i++) xdl_d[i] = xdl_q[i-1];
    end
  end

  // Stage 2: moving sums, add newest and drop the product leaving the window.
  always_comb begin
    pdl_re_d = pdl_re_q;
    pdl_im_d = pdl_im_q;
    pdl_p_d  = pdl_p_q;
    sum_re_d = sum_re_q;
    sum_im_d = sum_im_q;
    sum_r_d  = sum_r_q;
    if (adv && s1_valid_q) begin
      pdl_re_d[0] = s1_re_q;
      pdl_im_d[0] = s1_im_q;
      pdl_p_d[0]  = s1_p_q;
      for (int i = 1; i < WINDOW; i++) begin
        pdl_re_d[i] = pdl_re_q[i-1];
        pdl_im_d[i] = pdl_im_q[i-1];
        pdl_p_d[i]  = pdl_p_q[i-1];
      end
      sum_re_d = sum_re_q + SW'(s1_re_q) - SW'(pdl_re_q[WINDOW-1]);
      sum_im_d = sum_im_q + SW'(s1_im_q) - SW'(pdl_im_q[WINDOW-1]);
      sum_r_d  = sum_r_q + SW'(s1_p_q) - SW'(pdl_p_q[WINDOW-1]);
    end
  end

  // Stage 3: alpha-max-beta-min magnitude, threshold compare and plateau FSM.
  always_comb begin
    re_abs   = sum_re_q[SW-1] ? -sum_re_q : sum_re_q;
    im_abs   = sum_im_q[SW-1] ? -sum_im_q : sum_im_q;
    mx       = (re_abs > im_abs) ? re_abs : im_abs;
    mn       = (re_abs > im_abs) ? im_abs : re_abs;
    mag      = mx + (mn >> 2);
    r_thr    = {4'b0, sum_r_q} * (SW+4)'(THRESH);
    thr      = r_thr[SW+3:4];
    above    = (mag > thr) && (sum_r_q >= SW'(POWER_MIN));
    cnt_inc  = cnt_q + CW'(1);
    hcnt_inc = hcnt_q + HCW'(1);
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    evt      = 1'b0;
    if (adv && s2_valid_q) begin
      case (state_q)
        S_SEARCH: begin
          if (above) begin
            cnt_d   = CW'(1);
            state_d = S_PLATEAU;
          end
        end
        S_PLATEAU: begin
          if (!above) begin
            state_d = S_SEARCH;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(MIN_PLATEAU)) state_d = S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          cnt_d = cnt_inc;
          // Plateau drop and max length may coincide; either gives one tlast.
          if (!above || cnt_inc == CW'(MAX_PLATEAU)) begin
            evt     = 1'b1;
            hcnt_d  = '0;
            state_d = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == HCW'(HOLDOFF)) state_d = S_SEARCH;
        end
        default: state_d = S_SEARCH;
      endcase
    end
  end

  // Per-stage data/valid movement; everything holds while stalled.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    s1_p_d     = s1_p_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s3_valid_d = s3_valid_q;
    s3_data_d  = s3_data_q;
    s3_tlast_d = s3_tlast_q;
    o_tvalid_d = o_tvalid_q;
    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    if (adv) begin
      s1_valid_d = i_tvalid;
      s1_data_d  = i_tdata;
      s1_re_d    = c_re;
      s1_im_d    = c_im;
      s1_p_d     = c_p;
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_data_q;
      s3_valid_d = s2_valid_q;
      s3_data_d  = s2_data_q;
      s3_tlast_d = s2_valid_q & evt;
      o_tvalid_d = s3_valid_q;
      o_tdata_d  = s3_data_q;
      o_tlast_d  = s3_valid_q & s3_tlast_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PERIOD; i++) xdl_q[i] <= '0;
      for (int i = 0; i < WINDOW; i++) begin
        pdl_re_q[i] <= '0;
        pdl_im_q[i] <= '0;
        pdl_p_q[i]  <= '0;
      end
      sum_re_q   <= '0;
      sum_im_q   <= '0;
      sum_r_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_p_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_tlast_q <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      state_q    <= S_SEARCH;
      cnt_q      <= '0;
      hcnt_q     <= '0;
    end else begin
      xdl_q      <= xdl_d;
      pdl_re_q   <= pdl_re_d;
      pdl_im_q   <= pdl_im_d;
      pdl_p_q    <= pdl_p_d;
      sum_re_q   <= sum_re_d;
      sum_im_q   <= sum_im_d;
      sum_r_q    <= sum_r_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s1_p_q     <= s1_p_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s3_valid_q <= s3_valid_d;
      s3_data_q  <= s3_data_d;
      s3_tlast_q <= s3_tlast_d;
      o_tvalid_q <= o_tvalid_d;
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
    end
  end

`ifdef SHORT_PREAMBLE_DET_DEBUG_EN
  logic [SW-1:0] s3_mag_q, s3_pow_q, metric_q, power_q;

  // Debug metric/power travel with their sample through stages 3 and 4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_mag_q <= '0;
      s3_pow_q <= '0;
      metric_q <= '0;
      power_q  <= '0;
    end else if (adv) begin
      s3_mag_q <= mag;
      s3_pow_q <= sum_r_q;
      metric_q <= s3_mag_q;
      power_q  <= s3_pow_q;
    end
  end

  assign o_metric = metric_q;
  assign o_power  = power_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{i_tlast, r_thr[3:0]};

endmodule

// File: tb/tb_short_preamble_detector.sv
// Directed bench for short_preamble_detector: reset state, latency, plateau
// detection, forced tlast, short-burst rejection, backpressure and mid-run reset.
module tb_short_preamble_detector;
  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] TONE = 32'h1F40_0000;  // I=8000, Q=0

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [WIDTH-1:0] i_tdata = '0;
  logic i_tlast = 1'b0;
  logic i_tvalid = 1'b0;
  logic i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic o_tlast;
  logic o_tvalid;
  logic o_tready = 1'b1;
`ifdef SHORT_PREAMBLE_DET_DEBUG_EN
  logic [WIDTH+4:0] o_metric, o_power;
`endif

  short_preamble_detector dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
`ifdef SHORT_PREAMBLE_DET_DEBUG_EN
    .o_metric (o_metric),
    .o_power  (o_power),
`endif
    .o_tready (o_tready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic gaps = 1'b0;
  logic rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  int out_cnt = 0;
  int first_out_cyc = -1;
  int data_bad = 0;
  int stall_bad = 0;
  int tl_idx[$];
  int tl_cyc[$];
  logic [WIDTH-1:0] exp_q[$];
  int acc_cyc[$];
  logic prev_stall = 1'b0;
  logic prev_last = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      out_cnt = 0;
      first_out_cyc = -1;
      data_bad = 0;
      stall_bad = 0;
      tl_idx.delete();
      tl_cyc.delete();
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last))
        stall_bad++;
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      if (o_tvalid && o_tready) begin
        if (out_cnt == 0) first_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          data_bad++;
        end else begin
          if (o_tdata !== exp_q[0]) data_bad++;
          void'(exp_q.pop_front());
        end
        if (o_tlast) begin
          tl_idx.push_back(out_cnt);
          tl_cyc.push_back(cyc);
        end
        out_cnt++;
      end
    end
  end

  // Output ready: always high, or a coin toss each cycle.
  always @(posedge clk) begin
    #1;
    o_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic do_reset();
    i_tvalid = 1'b0;
    reset_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    acc_cyc.delete();
  endtask

  task automatic send(input logic [WIDTH-1:0] s);
    int waited = 0;
    logic ok = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    i_tdata = s;
    i_tvalid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = i_tready;
      if (ok) begin
        exp_q.push_back(s);
        acc_cyc.push_back(cyc);
      end
      @(posedge clk);
      #1;
      waited++;
      if (!ok && waited > 200) begin
        $display("FAIL send: i_tready low for %0d cycles, required high", waited);
        $fatal(1);
      end
    end
    i_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n);
    int k = 0;
    while (out_cnt < n && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (8) begin @(posedge clk); #1; end
    check({tag, " count"}, out_cnt, n);
  endtask

  function automatic logic [WIDTH-1:0] stim2(input int n);
    return (n < 160) ? TONE : '0;
  endfunction

  function automatic logic [WIDTH-1:0] noise();
    logic signed [15:0] a, b;
    a = ($urandom_range(0, 1) != 0) ? 16'sd2000 : -16'sd2000;
    b = ($urandom_range(0, 1) != 0) ? 16'sd2000 : -16'sd2000;
    return {a, b};
  endfunction

  function automatic int first_tl();
    return (tl_idx.size() > 0) ? tl_idx[0] : -1;
  endfunction

  function automatic int tl_at(input int k);
    return (tl_idx.size() > k) ? tl_idx[k] : -1;
  endfunction

  initial begin
    int pre_tl;
    int pre_bad;
    int lat;

    #2 reset_n = 1'b0;
    #1;
    check("reset o_tvalid", o_tvalid, 0);
    check("reset o_tlast", o_tlast, 0);
    check("reset o_tdata", o_tdata, 0);
    check("reset i_tready", i_tready, 1);
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;

    // Zeros: pure pass-through, no detection.
    do_reset();
    for (int n = 0; n < 2000; n++) send('0);
    drain("zeros", 2000);
    check("zeros latency", first_out_cyc - acc_cyc[0], 4);
    check("zeros tlast count", tl_idx.size(), 0);
    check("zeros data", data_bad, 0);

    // 160-sample tone then zeros: plateau ends at sample 163.
    do_reset();
    for (int n = 0; n < 400; n++) send(stim2(n));
    drain("tone160", 400);
    check("tone160 tlast count", tl_idx.size(), 0 + 1);
    check("tone160 tlast index", first_tl(), 163);
    lat = (tl_cyc.size() > 0) ? tl_cyc[0] - acc_cyc[163] : -1;
    check("tone160 tlast latency", lat, 4);
    check("tone160 data", data_bad, 0);

    // Constant tone: forced tlast at 271, then again after holdoff at 1039.
    do_reset();
    for (int n = 0; n < 1500; n++) send(TONE);
    drain("tone1500", 1500);
    check("tone1500 tlast count", tl_idx.size(), 2);
    check("tone1500 first tlast", tl_at(0), 271);
    check("tone1500 second tlast", tl_at(1), 1039);

    // 40-sample tone burst inside noise: run too short to qualify.
    do_reset();
    for (int n = 0; n < 300; n++) send((n >= 60 && n < 100) ? TONE : noise());
    drain("burst", 300);
    check("burst tlast count", tl_idx.size(), 0);
    check("burst data", data_bad, 0);

    // Backpressure and input gaps must not change detection or data.
    do_reset();
    gaps = 1'b1;
    rand_ready = 1'b1;
    for (int n = 0; n < 400; n++) send(stim2(n));
    drain("stall", 400);
    check("stall tlast count", tl_idx.size(), 1);
    check("stall tlast index", first_tl(), 163);
    check("stall data", data_bad, 0);
    check("stall hold", stall_bad, 0);
    gaps = 1'b0;
    rand_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset after sample 100, then replay from empty history.
    do_reset();
    for (int n = 0; n < 100; n++) send(stim2(n));
    pre_tl = tl_idx.size();
    pre_bad = data_bad;
    check("prereset tlast count", pre_tl, 0);
    check("prereset data", pre_bad, 0);
    do_reset();
    for (int n = 0; n < 400; n++) send(stim2(n));
    drain("replay", 400);
    check("replay tlast count", tl_idx.size(), 1);
    check("replay tlast index", first_tl(), 163);
    check("replay data", data_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
